// File: rtl/button_debounce_pkg.sv
// Shared types for the push-button debouncer.
// State encoding and counter sizing helper.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } db_state_e;

  function automatic int cnt_width(input int samples);
    return $clog2(samples + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous pins.
// Reset value is loadable so an idle pin never looks active.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_a,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/button_debounce_fsm.sv
// Strobe-qualified push-button debouncer with
// press/release pulses and a press counter.
module button_debounce_fsm
  import button_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       sample_tick,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic [7:0] press_cnt
);

  localparam int          CW   = cnt_width(STABLE_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES);
  localparam bit          ONE  = (STABLE_SAMPLES == 1);

  logic          pin_s;
  logic          btn_s;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [7:0]    press_q, press_d;
  logic          acc_press;
  logic          acc_rel;

  sync_ff #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_a (rst_a),
    .d_i   (btn_raw),
    .q_o   (pin_s)
  );

  assign btn_s = pin_s ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_press = 1'b0;
    acc_rel   = 1'b0;
    if (sample_tick) begin
      unique case (state_q)
        RELEASED: begin
          if (btn_s) begin
            if (ONE) begin
              state_d   = PRESSED;
              acc_press = 1'b1;
            end else begin
              state_d = PRESS_CHECK;
              cnt_d   = CW'(1);
            end
          end
        end
        PRESS_CHECK: begin
          if (!btn_s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == LAST) begin
            state_d   = PRESSED;
            cnt_d     = '0;
            acc_press = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            if (ONE) begin
              state_d = RELEASED;
              acc_rel = 1'b1;
            end else begin
              state_d = RELEASE_CHECK;
              cnt_d   = CW'(1);
            end
          end
        end
        RELEASE_CHECK: begin
          if (btn_s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
            acc_rel = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Pulses default low so they last exactly one clock.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    press_d = press_q;
    unique case (1'b1)
      acc_press: begin
        level_d = 1'b1;
        rise_d  = 1'b1;
        press_d = press_q + 8'd1;
      end
      acc_rel: begin
        level_d = 1'b0;
        fall_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign press_cnt = press_q;

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Bench for button_debounce_fsm: default and
// single-sample active-high instances.
module tb_button_debounce_fsm;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       sample_tick = 1'b0;
  logic       raw1 = 1'b1;
  logic       raw2 = 1'b0;
  logic       lvl1, rise1, fall1;
  logic       lvl2, rise2, fall2;
  logic [7:0] cnt1, cnt2;

  int checks = 0;
  int failures = 0;
  int nrise1 = 0, nfall1 = 0;
  int nrise2 = 0, nfall2 = 0;
  int viol = 0;
  logic prise1 = 1'b0, pfall1 = 1'b0;
  logic prise2 = 1'b0, pfall2 = 1'b0;
  int base;

  typedef struct {
    bit raw;
    int ticks;
    bit level;
    int cnt;
    int rises;
    int falls;
  } vec_t;

  typedef struct {
    string name;
    bit    level;
    int    cnt;
    int    rises;
    int    falls;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];

  button_debounce_fsm dut1 (
    .clk         (clk),
    .rst_a       (rst_a),
    .sample_tick (sample_tick),
    .btn_raw     (raw1),
    .btn_level   (lvl1),
    .btn_rise    (rise1),
    .btn_fall    (fall1),
    .press_cnt   (cnt1)
  );

  button_debounce_fsm #(
    .STABLE_SAMPLES (1),
    .ACTIVE_LOW     (1'b0),
    .SYNC_STAGES    (2)
  ) dut2 (
    .clk         (clk),
    .rst_a       (rst_a),
    .sample_tick (sample_tick),
    .btn_raw     (raw2),
    .btn_level   (lvl2),
    .btn_rise    (rise2),
    .btn_fall    (fall2),
    .press_cnt   (cnt2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rise1) nrise1 <= nrise1 + 1;
    if (fall1) nfall1 <= nfall1 + 1;
    if (rise2) nrise2 <= nrise2 + 1;
    if (fall2) nfall2 <= nfall2 + 1;
    if ((rise1 && fall1) || (rise1 && prise1) ||
        (fall1 && pfall1) || (rise2 && fall2) ||
        (rise2 && prise2) || (fall2 && pfall2))
      viol <= viol + 1;
    prise1 <= rise1;
    pfall1 <= fall1;
    prise2 <= rise2;
    pfall2 <= fall2;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 9; i++) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic tick_glitch();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      raw1 = !(i >= 2 && i < 5);
    end
    sample_tick = 1'b1;
    @(negedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    e.name  = $sformatf("vec%0d", idx);
    e.level = v.level;
    e.cnt   = v.cnt;
    e.rises = v.rises;
    e.falls = v.falls;
    sbq.push_back(e);
    raw1 = v.raw;
    repeat (v.ticks) tick();
    e = sbq.pop_front();
    chk({e.name, "_level"}, int'(lvl1), int'(e.level));
    chk({e.name, "_cnt"}, int'(cnt1), e.cnt);
    chk({e.name, "_rises"}, nrise1, e.rises);
    chk({e.name, "_falls"}, nfall1, e.falls);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3, 1'b1, 1, 1, 0};
    vecs[1] = '{1'b1, 1, 1'b0, 1, 1, 1};
    vecs[2] = '{1'b0, 2, 1'b0, 1, 1, 1};
    vecs[3] = '{1'b1, 1, 1'b0, 1, 1, 1};
    vecs[4] = '{1'b0, 3, 1'b0, 1, 1, 1};
    vecs[5] = '{1'b0, 1, 1'b1, 2, 2, 1};
    vecs[6] = '{1'b1, 2, 1'b1, 2, 2, 1};
    vecs[7] = '{1'b0, 1, 1'b1, 2, 2, 1};
    vecs[8] = '{1'b1, 3, 1'b1, 2, 2, 1};
    vecs[9] = '{1'b1, 1, 1'b0, 2, 2, 2};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_level", int'(lvl1), 0);
    chk("rst_rise", int'(rise1), 0);
    chk("rst_fall", int'(fall1), 0);
    chk("rst_cnt", int'(cnt1), 0);
    chk("rst_level2", int'(lvl2), 0);
    @(negedge clk);
    rst_a = 1'b1;

    raw1 = 1'b0;
    repeat (3) tick();
    chk("p1_pre_level", int'(lvl1), 0);
    chk("p1_pre_rise", int'(rise1), 0);
    tick();
    chk("p1_rise", int'(rise1), 1);
    chk("p1_level", int'(lvl1), 1);
    chk("p1_cnt", int'(cnt1), 1);
    @(negedge clk);
    #1 chk("p1_rise_drop", int'(rise1), 0);

    for (int i = 0; i < 10; i++) apply(vecs[i], i);

    repeat (4) tick_glitch();
    chk("gl_level", int'(lvl1), 0);
    chk("gl_cnt", int'(cnt1), 2);
    chk("gl_rises", nrise1, 2);
    chk("gl_falls", nfall1, 2);

    base = nrise1;
    raw1 = 1'b0;
    repeat (3) tick();
    chk("rc_pre_level", int'(lvl1), 0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("rc_level", int'(lvl1), 0);
    chk("rc_rise", int'(rise1), 0);
    chk("rc_fall", int'(fall1), 0);
    chk("rc_cnt", int'(cnt1), 0);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (3) tick();
    chk("rc_post3_level", int'(lvl1), 0);
    tick();
    chk("rc_post4_level", int'(lvl1), 1);
    chk("rc_post4_rise", int'(rise1), 1);
    chk("rc_post4_cnt", int'(cnt1), 1);

    raw1 = 1'b1;
    repeat (4) tick();
    chk("wr_rel_level", int'(lvl1), 0);
    for (int i = 0; i < 254; i++) begin
      raw1 = 1'b0;
      repeat (4) tick();
      raw1 = 1'b1;
      repeat (4) tick();
    end
    chk("wr_cnt255", int'(cnt1), 255);
    raw1 = 1'b0;
    repeat (4) tick();
    chk("wr_cnt0", int'(cnt1), 0);
    chk("wr_rises", nrise1 - base, 256);

    raw2 = 1'b1;
    tick();
    chk("s1_rise", int'(rise2), 1);
    chk("s1_level", int'(lvl2), 1);
    chk("s1_cnt", int'(cnt2), 1);

    @(negedge clk);
    sample_tick = 1'b1;
    raw2 = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("b2b_hold_level", int'(lvl2), 1);
    @(negedge clk);
    #1;
    chk("b2b_fall", int'(fall2), 1);
    chk("b2b_fall_level", int'(lvl2), 0);
    raw2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_rise", int'(rise2), 1);
    chk("b2b_cnt", int'(cnt2), 2);
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("s1_falls", nfall2, 1);
    chk("s1_rises", nrise2, 2);
    chk("pulse_rules", viol, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
